// File: rtl/qconv_pkg.sv
`default_nettype none
// ============================================================================
//  Package     : qconv_pkg
//  Description : Shared types and width/padding helpers for the streaming
//                quantised conv2d (qconv2d_stream) and its line buffer.
//  Revision    : 1.0 - initial release
// ============================================================================
package qconv_pkg;

    // Two-state stream controller: take input pixels, or present an output.
    typedef enum logic [0:0] {
        ACCEPT = 1'b0,
        EMIT   = 1'b1
    } state_e;

    // Width of one signed XB x KB product.
    function automatic int calc_mb(input int xb, input int kb);
        return xb + kb;
    endfunction

    // Width of the exact sum of KH*KW*XC products plus the bias.
    function automatic int calc_yb(input int xb, input int kb, input int kh,
                                   input int kw, input int xc);
        return calc_mb(xb, kb) + $clog2(kh * kw * xc + 1);
    endfunction

    function automatic int ceil_div(input int a, input int b);
        return (a + b - 1) / b;
    endfunction

    // Leading (top/left) SAME padding; total padding never goes below zero.
    function automatic int pad_lo(input int x, input int k, input int s);
        int p;
        if ((x % s) != 0) p = k - (x % s);
        else              p = k - s;
        if (p < 0) p = 0;
        return p / 2;
    endfunction

endpackage
`default_nettype wire

// File: rtl/qconv_line_buf.sv
`default_nettype none
// ============================================================================
//  Module      : qconv_line_buf
//  Description : KH-row circular line buffer (KH x XW pixels of XC x XB bits).
//                Input row r is stored in slot r mod KH. A KH x KW window is
//                read combinationally; taps outside the frame read as zero.
//                The pixel being written this cycle is forwarded into the
//                window so an output can be computed on its trigger beat.
//  Revision    : 1.0 - initial release
// ============================================================================
module qconv_line_buf #(
    parameter int XH = 8,
    parameter int XW = 8,
    parameter int XC = 1,
    parameter int KH = 3,
    parameter int KW = 3,
    parameter int XB = 11,
    parameter int CW = 16
) (
    input  logic                        clk,
    input  logic                        wr_en,
    input  logic [CW-1:0]               wr_row,
    input  logic [CW-1:0]               wr_col,
    input  logic [XC*XB-1:0]            wr_data,
    input  logic signed [CW-1:0]        win_row,
    input  logic signed [CW-1:0]        win_col,
    output logic [KH*KW*XC*XB-1:0]      win_data
);

    localparam int c_SLOT_W = (KH > 1) ? $clog2(KH) : 1;
    localparam int c_COL_W  = (XW > 1) ? $clog2(XW) : 1;

    logic [XC*XB-1:0]    r_mem [KH][XW];
    logic [c_SLOT_W-1:0] w_wr_slot;
    logic [c_COL_W-1:0]  w_wr_col;

    assign w_wr_slot = c_SLOT_W'(int'(wr_row) % KH);
    assign w_wr_col  = c_COL_W'(wr_col);

    // Circular row write; contents survive reset on purpose.
    always_ff @(posedge clk) begin
        if (wr_en) r_mem[w_wr_slot][w_wr_col] <= wr_data;
    end

    // Window read with zero padding and write-through of the incoming pixel.
    always_comb begin
        int r;
        int c;
        logic [XC*XB-1:0] px;
        win_data = '0;
        for (int kh = 0; kh < KH; kh++) begin
            for (int kw = 0; kw < KW; kw++) begin
                r  = int'(win_row) + kh;
                c  = int'(win_col) + kw;
                px = '0;
                if (r >= 0 && r < XH && c >= 0 && c < XW) begin
                    if (wr_en && r == int'(wr_row) && c == int'(wr_col))
                        px = wr_data;
                    else
                        px = r_mem[c_SLOT_W'(r % KH)][c_COL_W'(c)];
                end
                win_data[(kh*KW + kw)*XC*XB +: XC*XB] = px;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/qconv2d_stream.sv
`default_nettype none
// ============================================================================
//  Module      : qconv2d_stream
//  Description : Streaming quantised conv2d with TF-style SAME padding and
//                stride SH/SW. One input pixel (XC channels) or one output
//                pixel (YC channels) per cycle, raster order both sides.
//                Optional build macro QCONV2D_STREAM_RELU_EN clamps each
//                output channel at zero before registering.
//  Revision    : 1.0 - initial release
// ============================================================================
module qconv2d_stream
    import qconv_pkg::*;
#(
    parameter int XH = 8,
    parameter int XW = 8,
    parameter int XC = 1,
    parameter int YC = 8,
    parameter int KH = 3,
    parameter int KW = 3,
    parameter int SH = 2,
    parameter int SW = 2,
    parameter int XB = 11,
    parameter int KB = 6
) (
    input  logic                                          clk,
    input  logic                                          rst,
    input  logic [KH*KW*XC*YC*KB-1:0]                     k,
    input  logic [YC*KB-1:0]                              b,
    input  logic [XC*XB-1:0]                              s_data,
    input  logic                                          s_valid,
    output logic                                          s_ready,
    output logic [YC*calc_yb(XB, KB, KH, KW, XC)-1:0]     m_data,
    output logic                                          m_valid,
    input  logic                                          m_ready,
    output logic                                          m_last
);

    localparam int c_YH   = ceil_div(XH, SH);
    localparam int c_YW   = ceil_div(XW, SW);
    localparam int c_MB   = calc_mb(XB, KB);
    localparam int c_YB   = calc_yb(XB, KB, KH, KW, XC);
    localparam int c_PT   = pad_lo(XH, KH, SH);
    localparam int c_PL   = pad_lo(XW, KW, SW);
    localparam int c_CW   = 16;
    localparam int c_IH_W = $clog2(XH + 1);
    localparam int c_IW_W = $clog2(XW + 1);
    localparam int c_OH_W = $clog2(c_YH + 1);
    localparam int c_OW_W = $clog2(c_YW + 1);

    // Raster index of the input pixel whose arrival completes output (oh,ow).
    function automatic int trig_idx(input int oh, input int ow);
        int th;
        int tw;
        th = SH*oh + KH - 1 - c_PT;
        tw = SW*ow + KW - 1 - c_PL;
        if (th > XH - 1) th = XH - 1;
        if (tw > XW - 1) tw = XW - 1;
        return th*XW + tw;
    endfunction

    state_e              r_state;
    state_e              w_state_nx;
    logic [c_IH_W-1:0]   r_ih;
    logic [c_IW_W-1:0]   r_iw;
    logic [c_OH_W-1:0]   r_oh;
    logic [c_OW_W-1:0]   r_ow;

    int                  w_in_idx;
    int                  w_oh_nx;
    int                  w_ow_nx;
    int                  w_oh_sel;
    int                  w_ow_sel;
    logic                w_is_last;
    logic                w_acc;
    logic                w_load;
    logic                w_use_nx;
    logic                w_adv_out;
    logic                w_frame_end;

    logic [KH*KW*XC*XB-1:0] w_win;
    logic [YC*c_YB-1:0]     w_result;

    // Counter-derived positions: next input index and next output coordinates.
    always_comb begin
        w_in_idx  = int'(r_ih)*XW + int'(r_iw);
        w_is_last = (int'(r_oh) == c_YH - 1) && (int'(r_ow) == c_YW - 1);
        if (int'(r_ow) == c_YW - 1) begin
            w_ow_nx = 0;
            w_oh_nx = int'(r_oh) + 1;
        end else begin
            w_ow_nx = int'(r_ow) + 1;
            w_oh_nx = int'(r_oh);
        end
        w_oh_sel = w_use_nx ? w_oh_nx : int'(r_oh);
        w_ow_sel = w_use_nx ? w_ow_nx : int'(r_ow);
    end

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= ACCEPT;
        else     r_state <= w_state_nx;
    end

    // FSM next-state and handshake decode.
    always_comb begin
        w_state_nx  = r_state;
        s_ready     = 1'b0;
        w_acc       = 1'b0;
        w_load      = 1'b0;
        w_use_nx    = 1'b0;
        w_adv_out   = 1'b0;
        w_frame_end = 1'b0;
        case (r_state)
            ACCEPT: begin
                s_ready = 1'b1;
                if (s_valid) begin
                    w_acc = 1'b1;
                    // The pixel taken this cycle counts toward the trigger.
                    if (trig_idx(int'(r_oh), int'(r_ow)) <= w_in_idx) begin
                        w_load     = 1'b1;
                        w_state_nx = EMIT;
                    end
                end
            end
            EMIT: begin
                if (m_ready) begin
                    w_adv_out = 1'b1;
                    if (w_is_last) begin
                        w_frame_end = 1'b1;
                        w_state_nx  = ACCEPT;
                    end else if (trig_idx(w_oh_nx, w_ow_nx) < w_in_idx) begin
                        w_load   = 1'b1;
                        w_use_nx = 1'b1;
                    end else begin
                        w_state_nx = ACCEPT;
                    end
                end
            end
            default: w_state_nx = ACCEPT;
        endcase
    end

    // Input and output position counters; cleared at the end of every frame.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ih <= '0;
            r_iw <= '0;
            r_oh <= '0;
            r_ow <= '0;
        end else if (w_frame_end) begin
            r_ih <= '0;
            r_iw <= '0;
            r_oh <= '0;
            r_ow <= '0;
        end else begin
            if (w_acc) begin
                if (int'(r_iw) == XW - 1) begin
                    r_iw <= '0;
                    r_ih <= r_ih + 1'b1;
                end else begin
                    r_iw <= r_iw + 1'b1;
                end
            end
            if (w_adv_out) begin
                r_oh <= c_OH_W'(w_oh_nx);
                r_ow <= c_OW_W'(w_ow_nx);
            end
        end
    end

    qconv_line_buf #(
        .XH (XH),
        .XW (XW),
        .XC (XC),
        .KH (KH),
        .KW (KW),
        .XB (XB),
        .CW (c_CW)
    ) u_line_buf (
        .clk      (clk),
        .wr_en    (w_acc),
        .wr_row   (c_CW'(r_ih)),
        .wr_col   (c_CW'(r_iw)),
        .wr_data  (s_data),
        .win_row  (c_CW'(SH*w_oh_sel - c_PT)),
        .win_col  (c_CW'(SW*w_ow_sel - c_PL)),
        .win_data (w_win)
    );

    // Multiply-accumulate over the window for every output channel.
    always_comb begin
        logic signed [XB-1:0]   xv;
        logic signed [KB-1:0]   wv;
        logic signed [c_MB-1:0] prod;
        logic signed [c_YB-1:0] acc;
        w_result = '0;
        for (int y = 0; y < YC; y++) begin
            acc = c_YB'($signed(b[y*KB +: KB]));
            for (int t = 0; t < KH*KW; t++) begin
                for (int xc = 0; xc < XC; xc++) begin
                    xv   = $signed(w_win[(t*XC + xc)*XB +: XB]);
                    wv   = $signed(k[((t*XC + xc)*YC + y)*KB +: KB]);
                    prod = c_MB'(xv) * c_MB'(wv);
                    acc  = acc + c_YB'(prod);
                end
            end
`ifdef QCONV2D_STREAM_RELU_EN
            if (acc < 0) acc = '0;
`endif
            w_result[y*c_YB +: c_YB] = acc;
        end
    end

    // Output register: loaded on entry to EMIT or back-to-back, held until m_ready.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            m_data  <= '0;
            m_valid <= 1'b0;
            m_last  <= 1'b0;
        end else if (w_load) begin
            m_data  <= w_result;
            m_valid <= 1'b1;
            m_last  <= (w_oh_sel == c_YH - 1) && (w_ow_sel == c_YW - 1);
        end else if (w_adv_out) begin
            m_valid <= 1'b0;
            m_last  <= 1'b0;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_qconv2d_stream.sv
`default_nettype none
// ============================================================================
//  Module      : tb_qconv2d_stream
//  Description : Self-checking bench for qconv2d_stream on a 4x4, 3x3-kernel
//                configuration at stride 2 (u_s2) and stride 1 (u_s1).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_qconv2d_stream;

    localparam int XH = 4;
    localparam int XW = 4;
    localparam int XB = 11;
    localparam int KB = 6;
    localparam int YB = XB + KB + $clog2(3*3*1 + 1);

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    // stride-2 instance
    logic [9*KB-1:0] k2;
    logic [KB-1:0]   b2;
    logic [XB-1:0]   sd2;
    logic            sv2, sr2, mv2, mr2, ml2;
    logic [YB-1:0]   md2;
    // stride-1 instance
    logic [9*KB-1:0] k1;
    logic [KB-1:0]   b1;
    logic [XB-1:0]   sd1;
    logic            sv1, sr1, mv1, mr1, ml1;
    logic [YB-1:0]   md1;

    qconv2d_stream #(.XH(XH), .XW(XW), .XC(1), .YC(1), .KH(3), .KW(3),
                     .SH(2), .SW(2), .XB(XB), .KB(KB)) u_s2 (
        .clk(clk), .rst(rst), .k(k2), .b(b2),
        .s_data(sd2), .s_valid(sv2), .s_ready(sr2),
        .m_data(md2), .m_valid(mv2), .m_ready(mr2), .m_last(ml2));

    qconv2d_stream #(.XH(XH), .XW(XW), .XC(1), .YC(1), .KH(3), .KW(3),
                     .SH(1), .SW(1), .XB(XB), .KB(KB)) u_s1 (
        .clk(clk), .rst(rst), .k(k1), .b(b1),
        .s_data(sd1), .s_valid(sv1), .s_ready(sr1),
        .m_data(md1), .m_valid(mv1), .m_ready(mr1), .m_last(ml1));

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check_eq(input string tag, input longint got, input longint exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // ---------------- reference model (stride-generic, square 4x4, 3x3) ----
    int exp_q[$];
    int exp_last[$];

    task automatic model_frame(input int sh, input int x[$], input int kk[$], input int bb);
        int yo, ph, pt, acc, r, c;
        yo = (XH + sh - 1) / sh;
        ph = ((XH % sh) != 0) ? 3 - (XH % sh) : 3 - sh;
        if (ph < 0) ph = 0;
        pt = ph / 2;
        for (int oh = 0; oh < yo; oh++) begin
            for (int ow = 0; ow < yo; ow++) begin
                acc = bb;
                for (int kh = 0; kh < 3; kh++) begin
                    for (int kw = 0; kw < 3; kw++) begin
                        r = sh*oh + kh - pt;
                        c = sh*ow + kw - pt;
                        if (r >= 0 && r < XH && c >= 0 && c < XW)
                            acc += x[r*XW + c] * kk[kh*3 + kw];
                    end
                end
`ifdef QCONV2D_STREAM_RELU_EN
                if (acc < 0) acc = 0;
`endif
                exp_q.push_back(acc);
                exp_last.push_back((oh == yo-1 && ow == yo-1) ? 1 : 0);
            end
        end
    endtask

    // ---------------- monitors ----------------
    int   q_out2[$];
    int   q_last2[$];
    int   q_out1[$];
    int   q_last1[$];
    int   in_cnt2 = 0;
    bit   stall_prev = 0;
    bit   chk_bnd = 0;
    bit   bnd_pending = 0;
    bit   bnd_done = 0;
    logic [YB-1:0] md_prev;
    int   mr_pct = 100;

    always @(posedge clk) begin
        #1;
        mr2 = ($urandom_range(99) < mr_pct);
    end

    always @(negedge clk) begin
        if (rst) begin
            stall_prev  = 0;
            bnd_pending = 0;
        end else begin
            if (sv2 && sr2) in_cnt2++;
            if (mv2) check_eq("emit_sready", sr2, 0);
            if (stall_prev) begin
                check_eq("hold_valid", mv2, 1);
                check_eq("hold_data", md2, md_prev);
            end
            if (bnd_pending) begin
                check_eq("bnd_accept", sv2 && sr2, 1);
                bnd_pending = 0;
                bnd_done    = 1;
            end
            if (mv2 && mr2) begin
                q_out2.push_back(int'($signed(md2)));
                q_last2.push_back(int'(ml2));
                if (ml2 && chk_bnd) begin
                    bnd_pending = 1;
                    chk_bnd     = 0;
                end
            end
            stall_prev = mv2 && !mr2;
            md_prev    = md2;
        end
    end

    always @(negedge clk) begin
        if (!rst && mv1 && mr1) begin
            q_out1.push_back(int'($signed(md1)));
            q_last1.push_back(int'(ml1));
        end
    end

    initial begin
        #400000;
        $display("FAIL global_timeout: got 1 expected 0");
        $fatal(1);
    end

    // ---------------- stimulus helpers ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive2(input int px[$], input int gap_pct);
        int t;
        for (int i = 0; i < px.size(); i++) begin
            while ($urandom_range(99) < gap_pct) begin
                sv2 = 1'b0;
                step();
            end
            sv2 = 1'b1;
            sd2 = px[i][XB-1:0];
            t = 0;
            forever begin
                @(negedge clk);
                if (sr2) break;
                t++;
                if (t > 500) begin
                    check_eq("drv2_timeout", t, 0);
                    sv2 = 1'b0;
                    return;
                end
            end
            step();
        end
        sv2 = 1'b0;
    endtask

    task automatic drive1(input int px[$]);
        int t;
        for (int i = 0; i < px.size(); i++) begin
            sv1 = 1'b1;
            sd1 = px[i][XB-1:0];
            t = 0;
            forever begin
                @(negedge clk);
                if (sr1) break;
                t++;
                if (t > 500) begin
                    check_eq("drv1_timeout", t, 0);
                    sv1 = 1'b0;
                    return;
                end
            end
            step();
        end
        sv1 = 1'b0;
    endtask

    task automatic set_w2(input int kk[$], input int bb);
        for (int i = 0; i < 9; i++) k2[i*KB +: KB] = kk[i][KB-1:0];
        b2 = bb[KB-1:0];
    endtask

    task automatic prep2(input int x[$], input int kk[$], input int bb, input int nfr);
        q_out2.delete();
        q_last2.delete();
        exp_q.delete();
        exp_last.delete();
        set_w2(kk, bb);
        for (int f = 0; f < nfr; f++) model_frame(2, x[f*16 : f*16 + 15], kk, bb);
    endtask

    task automatic finish2(input string tag);
        int t;
        t = 0;
        while (q_out2.size() < exp_q.size() && t < 3000) begin
            @(negedge clk);
            t++;
        end
        repeat (6) @(negedge clk);
        check_eq($sformatf("%s_count", tag), q_out2.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < q_out2.size(); i++) begin
            check_eq($sformatf("%s_data%0d", tag, i), q_out2[i], exp_q[i]);
            check_eq($sformatf("%s_last%0d", tag, i), q_last2[i], exp_last[i]);
        end
        step();
    endtask

    function automatic int rnd_x();
        return int'($urandom_range(2047)) - 1024;
    endfunction

    function automatic int rnd_k();
        return int'($urandom_range(63)) - 32;
    endfunction

    // ---------------- test sequence ----------------
    initial begin
        int x[$];
        int kk[$];
        int bb;
        int t;
        int t1_exp[4];
        int exp00;

        rst = 1'b1;
        sv2 = 1'b0; sd2 = '0; k2 = '0; b2 = '0;
        sv1 = 1'b0; sd1 = '0; k1 = '0; b1 = '0; mr1 = 1'b1;
        repeat (3) step();
        check_eq("rst_mvalid", mv2, 0);
        check_eq("rst_mlast", ml2, 0);
        check_eq("rst_mdata", md2, 0);
        rst = 1'b0;
        step();
        check_eq("rst_sready", sr2, 1);

        // Test 1: stride 2, all ones
        t1_exp = '{9, 6, 6, 4};
        x.delete(); kk.delete();
        for (int i = 0; i < 16; i++) x.push_back(1);
        for (int i = 0; i < 9; i++) kk.push_back(1);
        mr_pct  = 100;
        in_cnt2 = 0;
        prep2(x, kk, 0, 1);
        fork
            drive2(x, 0);
            begin
                t = 0;
                while (!mv2 && t < 500) begin
                    @(negedge clk);
                    t++;
                end
                check_eq("t1_first_valid_after", in_cnt2, 11);
            end
        join
        finish2("t1");
        for (int i = 0; i < 4 && i < q_out2.size(); i++)
            check_eq($sformatf("t1_const%0d", i), q_out2[i], t1_exp[i]);

        // Test 2: stride 1, all ones -> corners 4, edges 6, interior 9
        for (int i = 0; i < 9; i++) k1[i*KB +: KB] = 6'd1;
        b1 = '0;
        q_out1.delete();
        q_last1.delete();
        drive1(x);
        t = 0;
        while (q_out1.size() < 16 && t < 500) begin
            @(negedge clk);
            t++;
        end
        repeat (4) @(negedge clk);
        check_eq("t2_count", q_out1.size(), 16);
        for (int i = 0; i < 16 && i < q_out1.size(); i++) begin
            int nb;
            nb = ((i / 4 == 0 || i / 4 == 3) ? 1 : 0) + ((i % 4 == 0 || i % 4 == 3) ? 1 : 0);
            check_eq($sformatf("t2_data%0d", i), q_out1[i], (nb == 2) ? 4 : (nb == 1) ? 6 : 9);
            check_eq($sformatf("t2_last%0d", i), q_last1[i], (i == 15) ? 1 : 0);
        end
        step();

        // Test 3: x=-1, k=3, b=5
`ifdef QCONV2D_STREAM_RELU_EN
        exp00 = 0;
`else
        exp00 = -22;
`endif
        x.delete(); kk.delete();
        for (int i = 0; i < 16; i++) x.push_back(-1);
        for (int i = 0; i < 9; i++) kk.push_back(3);
        prep2(x, kk, 5, 1);
        drive2(x, 0);
        finish2("t3");
        if (q_out2.size() > 0) check_eq("t3_out00", q_out2[0], exp00);
        else                   check_eq("t3_out00_missing", 0, 1);

        // Test 4: random data with backpressure and input gaps
        mr_pct = 30;
        x.delete(); kk.delete();
        for (int i = 0; i < 48; i++) x.push_back(rnd_x());
        for (int i = 0; i < 9; i++) kk.push_back(rnd_k());
        bb = rnd_k();
        prep2(x, kk, bb, 3);
        drive2(x, 30);
        finish2("t4");
        mr_pct = 100;

        // Test 5: reset after 7 inputs of a random frame, then an all-ones frame
        x.delete(); kk.delete();
        for (int i = 0; i < 7; i++) x.push_back(rnd_x());
        for (int i = 0; i < 9; i++) kk.push_back(1);
        set_w2(kk, 0);
        q_out2.delete();
        drive2(x, 0);
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        step();
        check_eq("t5_no_partial_out", q_out2.size(), 0);
        x.delete();
        for (int i = 0; i < 16; i++) x.push_back(1);
        prep2(x, kk, 0, 1);
        drive2(x, 0);
        finish2("t5");
        for (int i = 0; i < 4 && i < q_out2.size(); i++)
            check_eq($sformatf("t5_const%0d", i), q_out2[i], t1_exp[i]);

        // Test 6: two back-to-back random frames, s_valid always high
        x.delete(); kk.delete();
        for (int i = 0; i < 32; i++) x.push_back(rnd_x());
        for (int i = 0; i < 9; i++) kk.push_back(rnd_k());
        bb = rnd_k();
        prep2(x, kk, bb, 2);
        bnd_done = 0;
        chk_bnd  = 1;
        drive2(x, 0);
        finish2("t6");
        check_eq("t6_boundary_seen", bnd_done, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
